// File: rtl/d16_fetch_pkg.sv
// Shared definitions for the d16 fetch stage: word width, FSM encodings, reset PC.
// D16_FETCH_PC_EN widens the instruction FIFO so each entry carries its PC.
package d16_fetch_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

`ifdef D16_FETCH_PC_EN
    localparam int FIFO_W = 2 * WORD_W;
`else
    localparam int FIFO_W = WORD_W;
`endif

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_BUSY = 2'd1,
        FETCH_KILL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/d16_fetch_fifo.sv
// Synchronous instruction FIFO with flush; push and pop may coincide at any fill level.
module d16_fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/d16_fetch.sv
// d16 instruction fetch: owns the PC, issues strobe/ack reads, buffers words for decode.
// Build with D16_FETCH_PC_EN to carry each word's address out on ins_pc.
//
// state      | meaning
// FETCH_IDLE | no read outstanding
// FETCH_BUSY | read for pc outstanding
// FETCH_KILL | outstanding read invalidated by a jump, waiting for its ack
module d16_fetch
    import d16_fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        load,
    input  logic [15:0] mem_addr,
    output logic        imem_stb,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] ins,
`ifdef D16_FETCH_PC_EN
    output logic [15:0] ins_pc,
`endif
    output logic        ins_valid,
    input  logic        ins_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t      state, state_nxt;
    logic [15:0]       pc, pc_nxt, addr_nxt;
    logic              stb_nxt;
    logic              push, pop, full, empty;
    logic [CW-1:0]     count, count_nxt;
    logic [FIFO_W-1:0] fifo_din, fifo_dout;

    // A jump empties the FIFO, so any pop in the same cycle is meaningless.
    assign ins_valid = ~empty;
    assign pop       = ins_valid & ins_ready & ~load;
    assign push      = (state == FETCH_BUSY) & imem_ack & ~load;
    assign count_nxt = count + CW'(push) - CW'(pop);

`ifdef D16_FETCH_PC_EN
    assign fifo_din = {pc, imem_data};
    assign ins      = fifo_dout[15:0];
    assign ins_pc   = fifo_dout[31:16];
`else
    assign fifo_din = imem_data;
    assign ins      = fifo_dout;
`endif

    d16_fetch_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push),
        .pop   (pop),
        .flush (load),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= FETCH_IDLE;
            pc        <= RESET_PC;
            imem_stb  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_stb  <= stb_nxt;
            imem_addr <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        stb_nxt   = imem_stb;
        addr_nxt  = imem_addr;
        case (state)
            FETCH_IDLE: begin
                if (load) begin
                    pc_nxt    = mem_addr;
                    stb_nxt   = 1'b1;
                    addr_nxt  = mem_addr;
                    state_nxt = FETCH_BUSY;
                end else if (~full | pop) begin
                    stb_nxt   = 1'b1;
                    addr_nxt  = pc;
                    state_nxt = FETCH_BUSY;
                end
            end
            FETCH_BUSY: begin
                if (load) begin
                    pc_nxt = mem_addr;
                    if (imem_ack) begin
                        stb_nxt  = 1'b1;
                        addr_nxt = mem_addr;
                    end else begin
                        // The request cannot be withdrawn; let it complete and drop it.
                        state_nxt = FETCH_KILL;
                    end
                end else if (imem_ack) begin
                    pc_nxt = pc + 16'd1;
                    if (count_nxt < DEPTH_C) begin
                        stb_nxt  = 1'b1;
                        addr_nxt = pc + 16'd1;
                    end else begin
                        stb_nxt   = 1'b0;
                        state_nxt = FETCH_IDLE;
                    end
                end
            end
            FETCH_KILL: begin
                if (load) pc_nxt = mem_addr;
                if (imem_ack) begin
                    stb_nxt   = 1'b1;
                    addr_nxt  = pc_nxt;
                    state_nxt = FETCH_BUSY;
                end
            end
            default: begin
                stb_nxt   = 1'b0;
                state_nxt = FETCH_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_d16_fetch.sv
// Directed bench for d16_fetch: zero-wait memory returning addr ^ 16'hA500, DEPTH = 2.
module tb_d16_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    logic        imem_stb;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ins;
`ifdef D16_FETCH_PC_EN
    logic [15:0] ins_pc;
`endif
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic        ack_en = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    assign imem_ack  = imem_stb & ack_en;
    assign imem_data = imem_addr ^ 16'hA500;

    d16_fetch #(
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .load      (load),
        .mem_addr  (mem_addr),
        .imem_stb  (imem_stb),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ins       (ins),
`ifdef D16_FETCH_PC_EN
        .ins_pc    (ins_pc),
`endif
        .ins_valid (ins_valid),
        .ins_ready (ins_ready)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held from time zero
        step();
        check("rst_stb", {15'd0, imem_stb}, 16'd0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_valid", {15'd0, ins_valid}, 16'd0);
        check("rst_ins", ins, 16'h0000);
        sys_rst = 1'b0;

        // Streaming with zero-wait memory and a ready decoder
        step();
        check("s0_stb", {15'd0, imem_stb}, 16'd1);
        check("s0_addr", imem_addr, 16'h0000);
        check("s0_valid", {15'd0, ins_valid}, 16'd0);
        step();
        check("s1_addr", imem_addr, 16'h0001);
        check("s1_valid", {15'd0, ins_valid}, 16'd1);
        check("s1_ins", ins, 16'hA500);
`ifdef D16_FETCH_PC_EN
        check("s1_pc", ins_pc, 16'h0000);
`endif
        step();
        check("s2_addr", imem_addr, 16'h0002);
        check("s2_ins", ins, 16'hA501);
`ifdef D16_FETCH_PC_EN
        check("s2_pc", ins_pc, 16'h0001);
`endif
        step();
        check("s3_addr", imem_addr, 16'h0003);
        check("s3_ins", ins, 16'hA502);

        // Asynchronous reset while a read is outstanding
        #2;
        sys_rst   = 1'b1;
        ins_ready = 1'b0;
        #1;
        check("arst_stb", {15'd0, imem_stb}, 16'd0);
        check("arst_addr", imem_addr, 16'h0000);
        check("arst_valid", {15'd0, ins_valid}, 16'd0);
        check("arst_ins", ins, 16'h0000);
        step();
        sys_rst = 1'b0;

        // Restart at reset PC, then back-pressure fills the FIFO
        step();
        check("r0_stb", {15'd0, imem_stb}, 16'd1);
        check("r0_addr", imem_addr, 16'h0000);
        step();
        check("r1_addr", imem_addr, 16'h0001);
        check("r1_ins", ins, 16'hA500);
        step();
        check("full_stb", {15'd0, imem_stb}, 16'd0);
        check("full_ins", ins, 16'hA500);
        step();
        check("full_hold_stb", {15'd0, imem_stb}, 16'd0);
        ins_ready = 1'b1;
        step();
        check("resume_stb", {15'd0, imem_stb}, 16'd1);
        check("resume_addr", imem_addr, 16'h0002);
        check("resume_ins", ins, 16'hA501);
        ins_ready = 1'b0;
        step();
        check("refill_stb", {15'd0, imem_stb}, 16'd0);

        // Jump while full with a pop pending
        ins_ready = 1'b1;
        load      = 1'b1;
        mem_addr  = 16'h0100;
        step();
        load = 1'b0;
        check("jf_valid", {15'd0, ins_valid}, 16'd0);
        check("jf_stb", {15'd0, imem_stb}, 16'd1);
        check("jf_addr", imem_addr, 16'h0100);
        step();
        check("jf_ins", ins, 16'hA400);
        check("jf_next", imem_addr, 16'h0101);

        // Jump coincident with ack and pop; target FFFF then wrap
        load     = 1'b1;
        mem_addr = 16'hFFFF;
        step();
        load = 1'b0;
        check("ja_valid", {15'd0, ins_valid}, 16'd0);
        check("ja_addr", imem_addr, 16'hFFFF);
        step();
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_ins", ins, 16'h5AFF);
`ifdef D16_FETCH_PC_EN
        check("wrap_pc", ins_pc, 16'hFFFF);
`endif

        // Jump while busy without ack; stale word must be dropped
        ack_en   = 1'b0;
        load     = 1'b1;
        mem_addr = 16'h0040;
        step();
        load = 1'b0;
        check("k0_stb", {15'd0, imem_stb}, 16'd1);
        check("k0_addr", imem_addr, 16'h0000);
        check("k0_valid", {15'd0, ins_valid}, 16'd0);
        step();
        step();
        check("k2_addr", imem_addr, 16'h0000);
        check("k2_valid", {15'd0, ins_valid}, 16'd0);
        ack_en = 1'b1;
        step();
        check("k3_addr", imem_addr, 16'h0040);
        check("k3_valid", {15'd0, ins_valid}, 16'd0);
        step();
        check("k4_valid", {15'd0, ins_valid}, 16'd1);
        check("k4_ins", ins, 16'hA540);
        check("k4_addr", imem_addr, 16'h0041);
`ifdef D16_FETCH_PC_EN
        check("k4_pc", ins_pc, 16'h0040);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
